icache_refill_fsm: RTL and testbench

- Instruction-cache miss/refill controller sitting between the icache data/tag arrays and the interface router (bus interface unit).
- On a valid miss it stalls the fetch pipeline and issues a burst bus cycle of BEATS words.
- It then writes the assembled line into the cache and releases the stall.
- It also emits the translation-request pulses used by the icache/ITLB.

---
 rtl/icache_pkg.sv | 16 +
 rtl/icache_refill_fsm.sv | 109 ++++++++++
 tb/tb_icache_refill_fsm.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill controller:
// line geometry, bus byte-select constant and the FSM state encoding.
package icache_pkg;

  localparam int         LINE_W  = 256;
  localparam int         BEATS   = 8;
  localparam logic [3:0] SEL_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REFILL  = 2'b01,
    WRITE   = 2'b10,
    RESTART = 2'b11
  } state_e;

endpackage

// File: rtl/icache_refill_fsm.sv
// Icache miss/refill controller: stalls fetch on a miss, bursts BEATS words
// from the bus unit, writes the assembled line and restarts the fetch.
module icache_refill_fsm #(
  parameter int LINE_W = icache_pkg::LINE_W,
  parameter int BEATS  = icache_pkg::BEATS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              freeze_in,
  input  logic              i_hit,
  input  logic              tag_hit,
  input  logic              i_acc,
  input  logic [LINE_W-1:0] m_line_full,
  input  logic              wb_ack_i,
  output logic              i_we,
  output logic [LINE_W-1:0] i_data,
  output logic              stall,
  output logic [1:0]        state,
  output logic              vpn_to_ppn_req_out,
  output logic              vpn_to_ppn_req3,
  output logic              biu_cyc_i,
  output logic              biu_stb_i,
  output logic              biu_cab_i,
  output logic [3:0]        biu_sel_i
);

  import icache_pkg::*;

  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  state_e            state_q, state_d;
  logic [2:0]        beat_q, beat_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              req3_q;
  logic              miss;
  logic              unusedFreezeIn;

  // The refill never aborts on a freeze, so the raw core freeze has no effect here.
  assign unusedFreezeIn = freeze_in;

  assign miss            = i_acc && !i_hit && tag_hit && !freeze;
  assign state           = state_q;
  assign i_data          = line_q;
  assign vpn_to_ppn_req3 = req3_q;

  always_comb begin
    state_d            = state_q;
    beat_d             = beat_q;
    line_d             = line_q;
    stall              = 1'b0;
    i_we               = 1'b0;
    vpn_to_ppn_req_out = 1'b0;
    biu_cyc_i          = 1'b0;
    biu_stb_i          = 1'b0;
    biu_cab_i          = 1'b0;
    biu_sel_i          = 4'h0;
    case (state_q)
      IDLE: begin
        if (miss) begin
          stall   = 1'b1;
          beat_d  = 3'd0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        stall     = 1'b1;
        biu_cyc_i = 1'b1;
        biu_stb_i = 1'b1;
        biu_cab_i = 1'b1;
        biu_sel_i = SEL_ALL;
        if (wb_ack_i) begin
          // Counter wraps back to zero on the final beat.
          beat_d = beat_q + 3'd1;
          if (beat_q == LAST_BEAT) begin
            line_d  = m_line_full;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        stall              = 1'b1;
        i_we               = 1'b1;
        vpn_to_ppn_req_out = 1'b1;
        state_d            = RESTART;
      end
      RESTART: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      beat_q  <= 3'd0;
      line_q  <= '0;
      req3_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      req3_q  <= vpn_to_ppn_req_out;
    end
  end

endmodule

// File: tb/tb_icache_refill_fsm.sv
// Directed self-checking bench for icache_refill_fsm: reset, refill with
// back-to-back and gapped acks, freeze/tag gating, mid-refill reset, chained misses.
module tb_icache_refill_fsm;

  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          freeze, freeze_in, i_hit, tag_hit, i_acc, wb_ack_i;
  logic [LW-1:0] m_line_full;
  logic          i_we, stall, vpn_to_ppn_req_out, vpn_to_ppn_req3;
  logic          biu_cyc_i, biu_stb_i, biu_cab_i;
  logic [LW-1:0] i_data;
  logic [1:0]    state;
  logic [3:0]    biu_sel_i;

  int total = 0;
  int bad   = 0;
  int weCount = 0;

  icache_refill_fsm dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .freeze_in(freeze_in),
    .i_hit(i_hit), .tag_hit(tag_hit), .i_acc(i_acc), .m_line_full(m_line_full),
    .wb_ack_i(wb_ack_i), .i_we(i_we), .i_data(i_data), .stall(stall),
    .state(state), .vpn_to_ppn_req_out(vpn_to_ppn_req_out),
    .vpn_to_ppn_req3(vpn_to_ppn_req3), .biu_cyc_i(biu_cyc_i),
    .biu_stb_i(biu_stb_i), .biu_cab_i(biu_cab_i), .biu_sel_i(biu_sel_i)
  );

  always #5 clk = ~clk;

  // Count write-enable pulses mid-cycle, away from the active edge.
  always @(negedge clk) if (i_we) weCount++;

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic acc, input logic hit, input logic tag,
                               input logic frz, input logic ack);
    i_acc    = acc;
    i_hit    = hit;
    tag_hit  = tag;
    freeze   = frz;
    wb_ack_i = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues nAcks acks, each preceded by gap idle REFILL cycles, checking the bus strobes.
  task automatic refillAcks(input int nAcks, input int gap);
    for (int k = 0; k < nAcks; k++) begin
      for (int g = 0; g < gap; g++) begin
        wb_ack_i = 1'b0;
        #1;
        checkOutput("gap_state", LW'(state), LW'(2'b01));
        checkOutput("gap_cyc", LW'(biu_cyc_i & biu_stb_i & biu_cab_i), LW'(1'b1));
        tick();
      end
      wb_ack_i = 1'b1;
      #1;
      checkOutput("refill_state", LW'(state), LW'(2'b01));
      checkOutput("refill_bus", LW'({biu_cyc_i, biu_stb_i, biu_cab_i, biu_sel_i}), LW'(7'h7F));
      checkOutput("refill_stall", LW'(stall), LW'(1'b1));
      tick();
    end
    wb_ack_i = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] patA, patB;
    patA = {32{8'hA5}};
    patB = {8{32'h1234_5678}};
    rst_n = 1'b1;
    freeze_in = 1'b0;
    m_line_full = patA;
    applyStimulus(0, 0, 0, 0, 0);

    // 1. Reset
    tick(); tick();
    checkOutput("rst_state", LW'(state), LW'(2'b00));
    checkOutput("rst_stall", LW'(stall), LW'(1'b0));
    checkOutput("rst_we", LW'(i_we), LW'(1'b0));
    checkOutput("rst_cyc", LW'(biu_cyc_i), LW'(1'b0));
    checkOutput("rst_req3", LW'(vpn_to_ppn_req3), LW'(1'b0));
    checkOutput("rst_data", i_data, '0);
    rst_n = 1'b0;

    // 2. Miss refill, consecutive acks
    applyStimulus(1, 0, 1, 0, 0);
    #1;
    checkOutput("miss_stall", LW'(stall), LW'(1'b1));
    checkOutput("miss_state", LW'(state), LW'(2'b00));
    tick();
    refillAcks(8, 0);
    i_hit = 1'b1;
    #1;
    checkOutput("wr_state", LW'(state), LW'(2'b10));
    checkOutput("wr_we", LW'(i_we), LW'(1'b1));
    checkOutput("wr_data", i_data, patA);
    checkOutput("wr_vpn", LW'(vpn_to_ppn_req_out), LW'(1'b1));
    checkOutput("wr_cyc", LW'(biu_cyc_i), LW'(1'b0));
    checkOutput("wr_stall", LW'(stall), LW'(1'b1));
    tick();
    checkOutput("rs_state", LW'(state), LW'(2'b11));
    checkOutput("rs_stall", LW'(stall), LW'(1'b1));
    checkOutput("rs_req3", LW'(vpn_to_ppn_req3), LW'(1'b1));
    checkOutput("rs_we", LW'(i_we), LW'(1'b0));
    tick();
    checkOutput("idle_state", LW'(state), LW'(2'b00));
    checkOutput("idle_stall", LW'(stall), LW'(1'b0));
    checkOutput("idle_req3", LW'(vpn_to_ppn_req3), LW'(1'b0));

    // Ack while idle is ignored
    applyStimulus(1, 1, 1, 0, 1);
    tick();
    checkOutput("ack_idle_state", LW'(state), LW'(2'b00));

    // 3. Gapped acks
    weCount = 0;
    applyStimulus(1, 0, 1, 0, 0);
    tick();
    refillAcks(8, 2);
    checkOutput("gap_wr_state", LW'(state), LW'(2'b10));
    i_hit = 1'b1;
    tick(); tick();
    checkOutput("gap_end_state", LW'(state), LW'(2'b00));
    checkOutput("gap_we_count", LW'(weCount), LW'(1));

    // 4. Freeze / tag gating
    applyStimulus(1, 0, 1, 1, 0);
    #1;
    checkOutput("frz_stall", LW'(stall), LW'(1'b0));
    tick();
    checkOutput("frz_state", LW'(state), LW'(2'b00));
    applyStimulus(1, 0, 0, 0, 0);
    #1;
    checkOutput("tag_stall", LW'(stall), LW'(1'b0));
    tick();
    checkOutput("tag_state", LW'(state), LW'(2'b00));
    applyStimulus(1, 0, 1, 0, 0);
    tick();
    refillAcks(3, 0);
    freeze = 1'b1;
    freeze_in = 1'b1;
    refillAcks(5, 1);
    checkOutput("frz_mid_state", LW'(state), LW'(2'b10));
    checkOutput("frz_mid_we", LW'(i_we), LW'(1'b1));
    applyStimulus(1, 1, 1, 0, 0);
    freeze_in = 1'b0;
    tick(); tick();
    checkOutput("frz_end_state", LW'(state), LW'(2'b00));

    // 5. Reset mid-refill
    weCount = 0;
    applyStimulus(1, 0, 1, 0, 0);
    tick();
    refillAcks(4, 0);
    rst_n = 1'b1;
    i_acc = 1'b0;
    tick();
    checkOutput("mrst_state", LW'(state), LW'(2'b00));
    checkOutput("mrst_we", LW'(i_we), LW'(1'b0));
    rst_n = 1'b0;
    tick();
    checkOutput("mrst_we_count", LW'(weCount), LW'(0));
    i_acc = 1'b1;
    tick();
    refillAcks(7, 0);
    checkOutput("mrst_7acks", LW'(state), LW'(2'b01));
    refillAcks(1, 0);
    checkOutput("mrst_8acks", LW'(state), LW'(2'b10));
    i_hit = 1'b1;
    tick(); tick();

    // 6. Back-to-back misses
    m_line_full = patB;
    applyStimulus(1, 0, 1, 0, 0);
    tick();
    refillAcks(8, 0);
    checkOutput("b2b_data", i_data, patB);
    tick();
    checkOutput("b2b_rs", LW'(state), LW'(2'b11));
    tick();
    checkOutput("b2b_idle_state", LW'(state), LW'(2'b00));
    checkOutput("b2b_idle_stall", LW'(stall), LW'(1'b1));
    tick();
    checkOutput("b2b_refill", LW'(state), LW'(2'b01));
    m_line_full = patA;
    refillAcks(8, 0);
    checkOutput("b2b_data2", i_data, patA);
    i_hit = 1'b1;
    tick(); tick();
    checkOutput("b2b_end_state", LW'(state), LW'(2'b00));
    checkOutput("b2b_end_stall", LW'(stall), LW'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
